icache_direct_mapped: RTL and testbench
=======================================

// Module: icache_direct_mapped
// PURPOSE
// L1 instruction cache between the pipelined datapath's fetch stage and the
// memory controller. Serves imemREN/imemaddr from the datapath with a
// same-cycle ihit/imemload on hit. On miss, runs a single-word fill from
// memory via iREN/iaddr/iwait/iload. Direct-mapped, one word per frame,
// read-only; no write path.
// PARAMETERS
// SETS     16  number of frames; power of 2, >= 2
// WORD_W   32  data/address width
// CNT_W    32  width of hit/miss statistics counters
// PORTS
// CLK        in   1        clock, rising edge
// RST        in   1        async reset, active-high
// imemREN    in   1        datapath fetch request
// imemaddr   in   WORD_W   fetch byte address; bits [1:0] ignored
// ihit       out  1        fetch data valid this cycle
// imemload   out  WORD_W   fetched instruction
// iREN       out  1        memory read request
// iaddr      out  WORD_W   memory read address, word aligned
// iwait      in   1        memory busy; fill data valid when iREN && !iwait
// iload      in   WORD_W   memory read data
// hit_count  out  CNT_W    number of hit cycles accepted
// miss_count out  CNT_W    number of fills completed
// BEHAVIOUR
// - Address split: offset [1:0], index [IDX+1:2] (IDX = log2(SETS)), tag = rest.
// - Storage per frame: valid bit, tag, data word. RST clears all valid bits,
//   both counters, and the latched miss address. Tag and data are don't-care.
// - Reset outputs: ihit=0, imemload=0, iREN=0, iaddr=0, both counters 0.
// - FSM states: IDLE, FILL. Reset state is IDLE.
// - IDLE: hit = imemREN && valid[idx] && tag match. Hit drives ihit=1 and
//   imemload=data[idx] combinationally, with 0-cycle latency. Otherwise ihit=0
//   and imemload=0. A hit increments hit_count on the edge.
// - IDLE with imemREN && !hit: latch the word-aligned imemaddr and move to
//   FILL. ihit stays 0.
// - FILL: iREN=1 and iaddr=latched address. Both stay stable until the
//   transfer completes. ihit=0.
// - FILL with !iwait: on that edge, write the frame at the latched index
//   (valid=1, latched tag, iload), increment miss_count, and go to IDLE.
//   The re-lookup hits the cycle after the fill.
// - Miss penalty: 1 cycle to enter FILL + memory cycles until !iwait + 1 cycle
//   to re-look up.
// - Mid-fill changes: an imemaddr change (branch/jump redirect) or an imemREN
//   drop during FILL does not abort the fill. The latched address is filled
//   anyway. The new address is looked up in IDLE.
// - Conflict: a fill to an occupied index overwrites that frame
//   unconditionally.
// - Counters saturate at all-ones and do not wrap.
// - RST asserted during FILL: return to IDLE immediately, drop iREN, and
//   invalidate all frames. A partially completed fill is discarded.
// - imemREN=0 in IDLE: no state change, no counter change, all outputs 0.
// TESTING
// 1 Reset: assert RST mid-run, then release -> ihit=0, iREN=0, counters 0,
//   and the first fetch of 0x0 misses.
// 2 Cold miss: fetch 0x00000004, memory iwait=1 for 3 cycles, iload=0x00A00093
//   -> iREN/iaddr=0x4 held for 4 cycles; next cycle ihit=1 with
//   imemload=0x00A00093; miss_count=1.
// 3 Hit stream: fetch 0x4 for 5 cycles after the fill -> ihit=1 every cycle,
//   iREN=0, hit_count=5.
// 4 Conflict (SETS=16): fill 0x4, then fetch 0x44 (same index, new tag) ->
//   miss and fill. A following fetch of 0x4 misses again; miss_count=3.
// 5 Redirect mid-fill: fetch 0x8, then change imemaddr to 0x100 while iwait=1
//   -> iaddr stays 0x8 until !iwait. The next cycle misses on 0x100. 0x8 later
//   hits.
// 6 Reset mid-fill: assert RST while FILL with iwait=1 -> iREN=0 in the same
//   cycle. After release, 0x8 misses.

Source files
------------

// File: rtl/icache_direct_mapped.sv
// Direct-mapped, one-word-per-frame, read-only L1 instruction cache with hit/miss counters.
// Latency: a hit returns ihit/imemload in the same cycle; a miss costs 1 + memory wait cycles + 1.
// Backpressure: the fetch stage stalls on !ihit, and the fill holds iREN/iaddr steady while iwait is high.
module icache_direct_mapped #(
    parameter int SETS   = 16,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = WORD_W - IDX - 2;

    typedef enum logic {IDLE, FILL} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [SETS-1:0]     r_valid;
    logic [TAG_W-1:0]    r_tag  [SETS];
    logic [WORD_W-1:0]   r_data [SETS];
    logic [WORD_W-3:0]   r_miss_word;   // word address of the pending fill
    logic [CNT_W-1:0]    r_hit_count;
    logic [CNT_W-1:0]    r_miss_count;

    logic [IDX-1:0]      w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [IDX-1:0]      w_fill_idx;
    logic [TAG_W-1:0]    w_fill_tag;
    logic                w_hit;
    logic                w_start_miss;
    logic                w_fill_done;
    logic                w_unused;

    assign w_idx      = imemaddr[IDX+1:2];
    assign w_tag      = imemaddr[WORD_W-1:IDX+2];
    assign w_fill_idx = r_miss_word[IDX-1:0];
    assign w_fill_tag = r_miss_word[WORD_W-3:IDX];
    // Byte offset within the word has no meaning for an instruction fetch.
    assign w_unused   = &{1'b0, imemaddr[1:0]};

    assign w_hit        = (r_state == IDLE) && imemREN && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_start_miss = (r_state == IDLE) && imemREN && !w_hit;
    assign w_fill_done  = (r_state == FILL) && !iwait;

    // Fetch-side and memory-side outputs; everything is zero unless a hit or fill is active.
    always_comb begin
        ihit     = w_hit;
        imemload = w_hit ? r_data[w_idx] : '0;
        iREN     = (r_state == FILL);
        iaddr    = (r_state == FILL) ? {r_miss_word, 2'b00} : '0;
    end

    // Next state: a miss opens a fill, which runs to completion regardless of fetch-side changes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_miss) w_next = FILL;
            FILL:    if (!iwait)       w_next = IDLE;
            default:                   w_next = IDLE;
        endcase
    end

    // State register; reset aborts any fill in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Valid bits, miss address latch and saturating statistics counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_valid      <= '0;
            r_miss_word  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_start_miss)
                r_miss_word <= imemaddr[WORD_W-1:2];
            if (w_fill_done) begin
                r_valid[w_fill_idx] <= 1'b1;
                if (r_miss_count != '1)
                    r_miss_count <= r_miss_count + CNT_W'(1);
            end
            if (w_hit && (r_hit_count != '1))
                r_hit_count <= r_hit_count + CNT_W'(1);
        end
    end

    // Tag and data storage need no reset: valid bits gate every use.
    always_ff @(posedge CLK) begin
        if (w_fill_done) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= iload;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped: expected fetch data queued at lookup, compared on ihit.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Memory side is modelled by the stimulus tasks, which hold iwait for a chosen number of cycles.
module tb_icache_direct_mapped;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int          checks     = 0;
    int          failures   = 0;
    int          exp_hits   = 0;
    int          exp_misses = 0;
    logic [31:0] sb [$];

    icache_direct_mapped #(.SETS(16), .WORD_W(32), .CNT_W(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    // Memory contents seen by the cache, keyed on the word-aligned address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        if (a == 32'h4) return 32'h00A00093;
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_hit_count"},  hit_count,  exp_hits);
        chk({tag, "_miss_count"}, miss_count, exp_misses);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        imemREN = 1'b0;
        iwait = 1'b1;
        tick();
        RST = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
    endtask

    task automatic lookup_hit(input logic [31:0] addr);
        logic [31:0] exp_data;
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        sb.push_back(mem_word(addr));
        @(negedge CLK);
        chk("hit_ihit", {31'd0, ihit}, 32'd1);
        chk("hit_iren", {31'd0, iREN}, 32'd0);
        exp_data = sb.pop_front();
        if (ihit) chk("hit_data", imemload, exp_data);
        exp_hits++;
        tick();
    endtask

    task automatic lookup_miss(input logic [31:0] addr, input int waits,
                               input logic [31:0] mid_addr, input logic mid_ren);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        @(negedge CLK);
        chk("miss_ihit", {31'd0, ihit}, 32'd0);
        chk("miss_load", imemload, 32'd0);
        chk("miss_iren_idle", {31'd0, iREN}, 32'd0);
        tick();
        imemaddr = mid_addr;
        imemREN  = mid_ren;
        for (int i = 0; i <= waits; i++) begin
            iwait = (i < waits);
            iload = (i < waits) ? 32'hDEAD_BEEF : mem_word(addr);
            @(negedge CLK);
            chk("fill_iren",  {31'd0, iREN}, 32'd1);
            chk("fill_iaddr", iaddr, {addr[31:2], 2'b00});
            chk("fill_ihit",  {31'd0, ihit}, 32'd0);
            tick();
        end
        iwait = 1'b1;
        iload = 32'd0;
        exp_misses++;
    endtask

    initial begin
        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = 32'd0;
        iwait    = 1'b1;
        iload    = 32'd0;

        // Reset state.
        @(negedge CLK);
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_load", imemload, 32'd0);
        chk("rst_iren", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk_counts("rst");
        tick();
        RST = 1'b0;

        // Some activity, then a reset mid-run: counters clear and 0x0 misses again.
        lookup_miss(32'h0, 1, 32'h0, 1'b1);
        lookup_hit(32'h0);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrun_rst_hit_count", hit_count, 32'd0);
        chk("midrun_rst_miss_count", miss_count, 32'd0);
        tick();
        RST = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        lookup_miss(32'h0, 0, 32'h0, 1'b1);
        lookup_hit(32'h0);
        chk_counts("after_rst_refill");

        // Cold miss on 0x4 with three memory wait cycles, then a hit stream.
        do_reset();
        lookup_miss(32'h4, 3, 32'h4, 1'b1);
        chk("cold_miss_count", miss_count, 32'd1);
        for (int i = 0; i < 5; i++) lookup_hit(32'h4);
        chk("stream_hit_count", hit_count, 32'd5);
        lookup_hit(32'h7);   // byte offset bits ignored

        // Fetch disabled: outputs quiet, counters unchanged even though 0x4 is cached.
        imemREN  = 1'b0;
        imemaddr = 32'h4;
        @(negedge CLK);
        chk("noren_ihit", {31'd0, ihit}, 32'd0);
        chk("noren_load", imemload, 32'd0);
        chk("noren_iren", {31'd0, iREN}, 32'd0);
        tick();
        chk_counts("noren");

        // Conflict: 0x44 evicts 0x4 (same index), so 0x4 misses again.
        lookup_miss(32'h44, 2, 32'h44, 1'b1);
        lookup_hit(32'h44);
        lookup_miss(32'h4, 0, 32'h4, 1'b1);
        lookup_hit(32'h4);
        chk("conflict_miss_count", miss_count, 32'd3);
        chk_counts("conflict");

        // Redirect mid-fill: iaddr stays on 0x8, 0x100 misses afterwards, 0x8 then hits.
        lookup_miss(32'h8, 2, 32'h100, 1'b1);
        lookup_miss(32'h100, 1, 32'h100, 1'b1);
        lookup_hit(32'h8);
        lookup_hit(32'h100);
        // Fetch drop mid-fill does not abort the fill; a cached address seen during FILL must not hit.
        lookup_miss(32'hC, 1, 32'h8, 1'b0);
        lookup_miss(32'h10, 1, 32'h8, 1'b1);
        lookup_hit(32'hC);
        lookup_hit(32'h10);
        chk_counts("redirect");

        // Reset during a fill: iREN drops immediately and the fill is discarded.
        imemREN  = 1'b1;
        imemaddr = 32'h30;
        iwait    = 1'b1;
        tick();
        @(negedge CLK);
        chk("prerst_fill_iren", {31'd0, iREN}, 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("fillrst_iren", {31'd0, iREN}, 32'd0);
        chk("fillrst_iaddr", iaddr, 32'd0);
        chk("fillrst_ihit", {31'd0, ihit}, 32'd0);
        chk("fillrst_miss_count", miss_count, 32'd0);
        tick();
        RST = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        lookup_miss(32'h8, 1, 32'h8, 1'b1);
        lookup_hit(32'h8);
        lookup_miss(32'h30, 0, 32'h30, 1'b1);
        lookup_hit(32'h30);
        chk_counts("after_fill_rst");

        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
